// File: rtl/pc_sequencer.sv
// Program counter sequencer with a circular return-address stack and target alignment.
// Optional 2-byte instruction support is enabled by defining PC_SEQUENCER_COMPRESSED_EN.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            call,
    input  logic            ret,
    input  logic            is_compressed,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misaligned
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [XLEN-1:0] inc;
    logic [XLEN-1:0] align_mask;

`ifdef PC_SEQUENCER_COMPRESSED_EN
    assign inc        = is_compressed ? XLEN'(2) : XLEN'(4);
    assign align_mask = XLEN'(1);
`else
    logic unused_compressed;
    assign unused_compressed = is_compressed;
    assign inc               = XLEN'(4);
    assign align_mask        = XLEN'(3);
`endif

    logic [XLEN-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   top_idx;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] ras_top;
    logic            redirect;
    logic [XLEN-1:0] raw_target;
    logic [XLEN-1:0] next_pc;
    logic            push;
    logic            pop;

    // ptr is the next free slot, so the top of stack sits one below it
    assign top_idx     = ptr - PW'(1);
    assign ras_top     = ras[top_idx];
    assign pc_plus_inc = pc + inc;
    assign ras_empty   = (count == '0);
    assign ras_full    = (count == DEPTH_C);

    always_comb begin
        redirect   = 1'b0;
        raw_target = '0;
        if (branch_taken) begin
            redirect   = 1'b1;
            raw_target = branch_target;
        end else if (jump && ret && !ras_empty) begin
            redirect   = 1'b1;
            raw_target = ras_top;
        end else if (jump) begin
            redirect   = 1'b1;
            raw_target = jump_target;
        end
        next_pc = redirect ? (raw_target & ~align_mask) : pc_plus_inc;
        push    = !branch_taken && jump && call;
        pop     = !branch_taken && jump && ret && !ras_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_VECTOR;
            ptr        <= '0;
            count      <= '0;
            misaligned <= 1'b0;
        end else if (!stall) begin
            pc         <= next_pc;
            misaligned <= redirect && ((raw_target & align_mask) != '0);
            // call+ret together replaces the top in place, leaving ptr and count alone
            if (push && !pop) begin
                ptr <= ptr + PW'(1);
                if (count != DEPTH_C) begin
                    count <= count + CW'(1);
                end
            end else if (pop && !push) begin
                ptr   <= ptr - PW'(1);
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !stall) begin
            if (push && pop) begin
                ras[top_idx] <= pc_plus_inc;
            end else if (push) begin
                ras[ptr] <= pc_plus_inc;
            end
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL provide parameter XLEN, 32, width of all address ports.
REQ-002 The block SHALL provide parameter RESET_VECTOR, 0, value loaded into pc on reset.
REQ-003 The block SHALL provide parameter RAS_DEPTH, 4, number of return-address-stack entries; legal range 2..16, power of two.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have clk, input, 1, the single rising-edge clock.
REQ-005 The block SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have stall, input, 1, which freezes all state.
REQ-007 The block SHALL have branch_taken, input, 1, and branch_target, input, XLEN, for conditional redirect.
REQ-008 The block SHALL have jump, input, 1, and jump_target, input, XLEN, for unconditional redirect.
REQ-009 The block SHALL have call, input, 1, qualified by jump, which pushes the return address.
REQ-010 The block SHALL have ret, input, 1, qualified by jump, which pops the return address.
REQ-011 The block SHALL have is_compressed, input, 1, meaning the current instruction is 2 bytes; it is ignored unless COMPRESSED_EN is defined.
REQ-012 The block SHALL have pc, output, XLEN, the registered program counter.
REQ-013 The block SHALL have pc_plus_inc, output, XLEN, combinational pc plus the instruction size.
REQ-014 The block SHALL have ras_empty, output, 1, and ras_full, output, 1, as registered stack status flags.
REQ-015 The block SHALL have misaligned, output, 1, a registered flag meaning the last redirect target was misaligned.

Function
REQ-016 The increment SHALL be 4; with COMPRESSED_EN and is_compressed=1 it SHALL be 2; addition SHALL be modulo 2^XLEN, so 0xFFFFFFFC+4 gives 0.
REQ-017 The next-pc priority SHALL be: stall (hold) > branch_taken (branch_target) > jump with ret and RAS non-empty (RAS top) > jump (jump_target) > pc_plus_inc.
REQ-018 pc SHALL update on the rising clk edge, one cycle after the inputs are sampled, with no added latency.
REQ-019 On jump&call with no stall and no branch_taken, the block SHALL push pc_plus_inc onto the RAS.
REQ-020 On jump&ret with no stall and no branch_taken, the block SHALL pop the RAS if it is non-empty; a pop on an empty RAS SHALL leave the RAS unchanged and jump_target SHALL be taken.
REQ-021 When call and ret are asserted together, the redirect target SHALL be the old top and the top SHALL be replaced with pc_plus_inc; the count is unchanged, and on an empty RAS this is a plain push.
REQ-022 A push on a full RAS SHALL overwrite the oldest entry as a circular buffer; the count SHALL saturate at RAS_DEPTH and ras_full SHALL remain 1.
REQ-023 ras_empty SHALL equal (count==0) and ras_full SHALL equal (count==RAS_DEPTH), both derived from the registered count.
REQ-024 A redirect target whose alignment bits are nonzero SHALL be loaded with those bits cleared, and misaligned SHALL be 1 for exactly the following cycle; the alignment bits are [1:0], or [0] only with COMPRESSED_EN.
REQ-025 call or ret without jump SHALL be ignored.
REQ-026 While stall=1, pc, the RAS, the count and misaligned SHALL all hold.

Reset
REQ-027 While rst_n=0, asynchronously and independent of clk: pc=RESET_VECTOR, count=0, ras_empty=1, ras_full=0, misaligned=0; RAS entry contents are don't-care.
REQ-028 Reset asserted mid-operation SHALL abort any pending push or pop; the first edge after rst_n rises SHALL load RESET_VECTOR plus the increment.

Configuration
REQ-029 The block SHALL support macro PC_SEQUENCER_COMPRESSED_EN.
- Defined: is_compressed selects a 2-byte increment and 2-byte alignment.
- Undefined: increment is fixed at 4, alignment is 4 bytes, and is_compressed is unused.

Verification
REQ-030 Release reset with RESET_VECTOR=0x100 and run 3 idle cycles -> pc=0x100, 0x104, 0x108, 0x10C; ras_empty=1.
REQ-031 At pc=0x200 drive jump&call with jump_target=0x800, then at 0x804 drive jump&ret -> pc=0x800, then 0x804, then 0x204; ras_empty goes 0 then back to 1.
REQ-032 Drive 5 calls with RAS_DEPTH=4 -> ras_full=1 after the 4th and stays 1; 4 rets then return the 5th, 4th, 3rd and 2nd return addresses; the 5th ret with ras_empty=1 takes jump_target.
REQ-033 Drive branch_taken&jump&ret together with branch_target=0x40 -> pc=0x40 and the RAS count is unchanged; stall=1 for 2 cycles with any inputs -> pc and the flags are unchanged.
REQ-034 Drive jump with jump_target=0x1002 -> pc=0x1000 and misaligned=1 for one cycle (macro undefined); with the macro defined and is_compressed=1 at pc=0x10 -> pc_plus_inc=0x12.
